// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: walks an inclusive wrap-around index range over one regfile read port
// and streams (index, data) beats over valid/ready.
module regfile_dump_reader #(
    parameter int N      = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [ADDR_W-1:0] first_i,
    input  logic [ADDR_W-1:0] last_i,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [N-1:0]      rd_data_i,
    output logic              dump_valid_o,
    input  logic              dump_ready_i,
    output logic [ADDR_W-1:0] dump_index_o,
    output logic [N-1:0]      dump_data_o,
    output logic              busy_o,
    output logic              done_o
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] SEND  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]        state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] last_q;
    logic [ADDR_W-1:0] ptr_nx;

    assign ptr_nx = ptr + ADDR_W'(1);
    // In SEND the port already looks one ahead so the next beat is captured on the handshake edge.
    assign rd_addr_o = (state == FETCH) ? ptr : (state == SEND) ? ptr_nx : '0;
    assign busy_o    = (state == FETCH) || (state == SEND);
    assign done_o    = (state == DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            ptr          <= '0;
            last_q       <= '0;
            dump_index_o <= '0;
            dump_data_o  <= '0;
            dump_valid_o <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start_i) begin
                    ptr    <= first_i;
                    last_q <= last_i;
                    state  <= FETCH;
                end
                FETCH: if (abort_i) begin
                    state <= IDLE;
                end else begin
                    dump_data_o  <= rd_data_i;
                    dump_index_o <= ptr;
                    dump_valid_o <= 1'b1;
                    state        <= SEND;
                end
                SEND: if (abort_i) begin
                    dump_valid_o <= 1'b0;
                    state        <= IDLE;
                end else if (dump_valid_o && dump_ready_i) begin
                    if (ptr != last_q) begin
                        ptr          <= ptr_nx;
                        dump_index_o <= ptr_nx;
                        dump_data_o  <= rd_data_i;
                    end else begin
                        dump_valid_o <= 1'b0;
                        state        <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb_regfile_dump_reader: directed vector table plus hand-written sequences for stalls, abort and reset.
module tb_regfile_dump_reader;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic [4:0]  first_i = '0;
    logic [4:0]  last_i = '0;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_i;
    logic        dump_valid_o;
    logic        dump_ready_i = 1'b1;
    logic [4:0]  dump_index_o;
    logic [31:0] dump_data_o;
    logic        busy_o;
    logic        done_o;

    logic [31:0] regs [32];
    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [4:0] f;
        logic [4:0] l;
        int         n;
    } vec_t;
    vec_t tbl [6];

    always #5 clk = ~clk;
    assign rd_data_i = regs[rd_addr_o];

    regfile_dump_reader #(.N(32), .ADDR_W(5)) dut (
        .clk(clk), .reset(reset), .start_i(start_i), .abort_i(abort_i),
        .first_i(first_i), .last_i(last_i), .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i),
        .dump_valid_o(dump_valid_o), .dump_ready_i(dump_ready_i), .dump_index_o(dump_index_o),
        .dump_data_o(dump_data_o), .busy_o(busy_o), .done_o(done_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input int n, input bit poke);
        int k = 0;
        int nbusy = 0;
        bit seen_done = 0;
        logic [4:0] ei;
        first_i = f;
        last_i = l;
        start_i = 1'b1;
        dump_ready_i = 1'b1;
        for (int c = 0; c < 100 && !seen_done; c++) begin
            @(negedge clk);
            if (c == 0) begin
                start_i = 1'b0;
                chk("fetch_addr", 32'(rd_addr_o), 32'(f));
                chk("fetch_valid", 32'(dump_valid_o), 32'd0);
            end
            if (poke && c == 1) begin
                start_i = 1'b1;
                first_i = 5'd9;
                last_i = 5'd9;
            end
            if (poke && c == 2) start_i = 1'b0;
            if (busy_o) nbusy++;
            if (dump_valid_o) begin
                ei = f + k[4:0];
                chk("beat_index", 32'(dump_index_o), 32'(ei));
                chk("beat_data", dump_data_o, 32'hA500_0000 | 32'(ei));
                k++;
            end
            if (done_o) seen_done = 1;
        end
        chk("done_seen", 32'(seen_done), 32'd1);
        chk("beat_count", 32'(k), 32'(n));
        chk("busy_cycles", 32'(nbusy), 32'(n + 1));
        if (poke) start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        chk("after_done_busy", 32'(busy_o), 32'd0);
        chk("after_done_pulse", 32'(done_o), 32'd0);
        chk("after_done_valid", 32'(dump_valid_o), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'hA500_0000 | 32'(i);
        tbl[0] = '{5'd0, 5'd31, 32};
        tbl[1] = '{5'd30, 5'd1, 4};
        tbl[2] = '{5'd7, 5'd7, 1};
        tbl[3] = '{5'd31, 5'd0, 2};
        tbl[4] = '{5'd31, 5'd31, 1};
        tbl[5] = '{5'd4, 5'd6, 3};
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(dump_valid_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_index", 32'(dump_index_o), 32'd0);
        chk("rst_data", dump_data_o, 32'd0);
        chk("rst_addr", 32'(rd_addr_o), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        for (int t = 0; t < 6; t++) run_dump(tbl[t].f, tbl[t].l, tbl[t].n, 1'b0);

        // backpressure on index 5 with a regfile write during the stall
        first_i = 5'd4; last_i = 5'd6; start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        @(negedge clk);
        chk("bp_idx4", 32'(dump_index_o), 32'd4);
        @(negedge clk);
        chk("bp_idx5", 32'(dump_index_o), 32'd5);
        dump_ready_i = 1'b0;
        regs[5] = 32'hDEAD_BEEF;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            chk("bp_stall_valid", 32'(dump_valid_o), 32'd1);
            chk("bp_stall_idx", 32'(dump_index_o), 32'd5);
            chk("bp_stall_data", dump_data_o, 32'hA500_0005);
        end
        dump_ready_i = 1'b1;
        @(negedge clk);
        chk("bp_idx6", 32'(dump_index_o), 32'd6);
        chk("bp_data6", dump_data_o, 32'hA500_0006);
        @(negedge clk);
        chk("bp_done", 32'(done_o), 32'd1);
        chk("bp_done_valid", 32'(dump_valid_o), 32'd0);
        regs[5] = 32'hA500_0005;
        @(negedge clk);

        // abort in the cycle after beat 3 handshakes
        first_i = 5'd0; last_i = 5'd31; start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("ab_idx", 32'(dump_index_o), 32'(k));
        end
        @(negedge clk);
        chk("ab_idx4", 32'(dump_index_o), 32'd4);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        chk("ab_valid", 32'(dump_valid_o), 32'd0);
        chk("ab_busy", 32'(busy_o), 32'd0);
        chk("ab_done", 32'(done_o), 32'd0);
        @(negedge clk);
        chk("ab_done2", 32'(done_o), 32'd0);
        run_dump(5'd2, 5'd2, 1, 1'b0);

        // start pulsed while busy and during DONE is ignored
        run_dump(5'd0, 5'd3, 4, 1'b1);

        // asynchronous reset during beat 10
        first_i = 5'd0; last_i = 5'd31; start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        for (int c = 0; c < 40 && !(dump_valid_o && dump_index_o == 5'd10); c++) @(negedge clk);
        chk("rs_at_beat10", 32'(dump_index_o), 32'd10);
        #2 reset = 1'b0;
        #1;
        chk("rs_valid", 32'(dump_valid_o), 32'd0);
        chk("rs_busy", 32'(busy_o), 32'd0);
        chk("rs_done", 32'(done_o), 32'd0);
        chk("rs_index", 32'(dump_index_o), 32'd0);
        chk("rs_data", dump_data_o, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rs_idle", 32'(busy_o), 32'd0);
        run_dump(5'd5, 5'd8, 4, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
- Sequential read-out engine on the read side of the 32-entry register file.
- On a start request it walks an inclusive, wrap-around range of register indices through one register-file read port.
- It streams each (index, data) pair out over a valid/ready interface for debug, trace or checkpoint capture.
- It sits beside the register file, sharing one read-address/read-data pair. The register-file read is combinational, same cycle.

Parameters:
- N, 32, data width of each register and of dump_data_o.
- ADDR_W, 5, register index width; number of registers is 2**ADDR_W (32).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- start_i  input  1  begin a dump; sampled only in IDLE
- abort_i  input  1  synchronous cancel of a dump in progress
- first_i  input  ADDR_W  first index of range; latched on accepted start
- last_i  input  ADDR_W  last index of range, inclusive; latched on accepted start
- rd_addr_o  output  ADDR_W  read address to register file read port
- rd_data_i  input  N  read data from register file; combinational from rd_addr_o
- dump_valid_o  output  1  output beat valid
- dump_ready_i  input  1  downstream accepts beat
- dump_index_o  output  ADDR_W  index of current beat
- dump_data_o  output  N  register value of current beat
- busy_o  output  1  dump in progress
- done_o  output  1  one-cycle pulse after final beat accepted

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; ptr, last_q, dump_index_o, dump_data_o = 0; dump_valid_o, busy_o, done_o = 0.
- States: IDLE, FETCH, SEND, DONE.
- IDLE
  - start_i=1: ptr<=first_i, last_q<=last_i, next state FETCH.
  - rd_addr_o=0.
- FETCH
  - rd_addr_o=ptr.
  - At the edge: dump_data_o<=rd_data_i, dump_index_o<=ptr, dump_valid_o<=1, next state SEND.
- SEND
  - rd_addr_o=ptr+1, mod 2**ADDR_W.
  - Handshake = dump_valid_o & dump_ready_i.
  - Handshake with ptr!=last_q: ptr<=ptr+1, dump_index_o<=ptr+1, dump_data_o<=rd_data_i, dump_valid_o stays 1. This gives one beat per cycle when dump_ready_i is held high.
  - Handshake with ptr==last_q: dump_valid_o<=0, next state DONE.
  - No handshake: dump_index_o and dump_data_o held stable. A write to the register file during a stall does not alter the presented beat; the value is the one captured at the capture edge.
- DONE
  - done_o=1 for exactly this one cycle.
  - Next state IDLE.
- Latency
  - start_i sampled at edge E0; first beat valid after E1.
  - Beat k (0-based) is captured at the edge where beat k-1 handshakes.
- Range
  - Beat count = ((last_q - first) mod 2**ADDR_W) + 1; range 1..32.
  - first==last gives 1 beat.
  - last<first wraps through 31 to 0.
  - first=0, last=31 gives all 32 registers.
- busy_o=1 in FETCH and SEND; 0 in IDLE and DONE.
- start_i while not IDLE is ignored, including in DONE. A new start is accepted in the cycle after DONE, when the state is IDLE.
- abort_i=1 in FETCH or SEND (priority over handshake)
  - Next state IDLE, dump_valid_o<=0, no done_o pulse.
  - A beat handshaking in the same cycle counts as not delivered.
- abort_i in IDLE or DONE: no effect.
- Reset mid-operation: all outputs go to reset values immediately. The dump is not resumed.
- first_i and last_i changing after start is accepted have no effect.

Test Plan:
- Full dump: preload R[i]=0xA5000000|i, first=0, last=31, ready=1 -> 32 consecutive beats, index 0..31, data 0xA5000000..0xA500001F. done_o pulses the cycle after beat 31; busy_o is high for 33 cycles (FETCH + 32 SEND).
- Wrap and single: first=30, last=1 -> indices 30,31,0,1 (4 beats). Then first=last=7 -> exactly one beat, index 7, data 0xA5000007, then done_o.
- Backpressure and stability: first=4, last=6, ready low 3 cycles on beat index 5; write R[5]=0xDEADBEEF during the stall -> beat shows 0xA5000005 throughout the stall. Beat 6 follows, total 3 beats.
- Abort: full range, abort_i=1 in the cycle after beat 3 handshakes -> dump_valid_o=0 and busy_o=0 next cycle, no done_o pulse. A following start with first=2, last=2 yields one beat, index 2.
- Start while busy: start_i pulsed with first=9 during an active dump of 0..3 -> ignored, only indices 0..3 emitted.
- Reset mid-dump: reset=0 asynchronously during beat 10 -> dump_valid_o, busy_o, done_o, dump_data_o, dump_index_o = 0 without waiting for a clock edge. After release the block is IDLE and accepts a new start.
